// File: rtl/seq_divider_pkg.sv
// Shared state encoding and sizing helper for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cntWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_con.sv
// Control for the sequential divider: FSM, iteration counter and datapath strobes.
module seq_divider_con
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic load_en_o,
  output logic shift_en_o,
  output logic out_en_o,
  output logic readyo_o,
  output logic busy_o
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // After the final iteration CALC spends one more cycle registering the results.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    load_en_o  = 1'b0;
    shift_en_o = 1'b0;
    out_en_o   = 1'b0;
    readyo_o   = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load_en_o = 1'b1;
          cnt_d     = '0;
          last_d    = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (last_q) begin
          out_en_o = 1'b1;
          state_d  = DONE;
        end else begin
          shift_en_o = 1'b1;
          if (cnt_q == LAST_CNT) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        busy_o   = 1'b1;
        readyo_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, START/READYO handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands and results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o,
  output logic             readyo_o
);

  logic loadEn, shiftEn, outEn;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvsMag_q, dvsMag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divZero_q, divZero_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             dvsNeg_q, dvsNeg_d;
`endif

  logic [WIDTH:0]   trial;
  logic             trialNeg;
  logic             divZero;
  logic [WIDTH-1:0] quoFinal, remFinal;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef SEQ_DIVIDER_SIGNED_EN
    return v[WIDTH-1] ? -v : v;
`else
    return v;
`endif
  endfunction

  seq_divider_con #(
    .WIDTH(WIDTH)
  ) u_con (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .load_en_o (loadEn),
    .shift_en_o(shiftEn),
    .out_en_o  (outEn),
    .readyo_o  (readyo_o),
    .busy_o    (busy_o)
  );

  // One extra bit on the trial difference exposes the borrow as its sign.
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsMag_q};
  assign trialNeg = trial[WIDTH];

  always_comb begin
    divZero = (dvsMag_q == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    quoFinal = (dvd_q[WIDTH-1] ^ dvsNeg_q) ? -quo_q : quo_q;
    remFinal = dvd_q[WIDTH-1] ? -rem_q : rem_q;
`else
    quoFinal = quo_q;
    remFinal = rem_q;
`endif
    if (divZero) begin
      quoFinal = '1;
      remFinal = dvd_q;
    end
  end

  always_comb begin
    dvd_d       = dvd_q;
    dvsMag_d    = dvsMag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divZero_d   = divZero_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvsNeg_d    = dvsNeg_q;
`endif
    if (loadEn) begin
      dvd_d    = dividend_i;
      dvsMag_d = magnitude(divisor_i);
      rem_d    = '0;
      quo_d    = magnitude(dividend_i);
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvsNeg_d = divisor_i[WIDTH-1];
`endif
    end
    if (shiftEn) begin
      rem_d = trialNeg ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trialNeg};
    end
    if (outEn) begin
      quotient_d  = quoFinal;
      remainder_d = remFinal;
      divZero_d   = divZero;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd_q       <= '0;
      dvsMag_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvsNeg_q    <= 1'b0;
`endif
    end else begin
      dvd_q       <= dvd_d;
      dvsMag_q    <= dvsMag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvsNeg_q    <= dvsNeg_d;
`endif
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = divZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at START, popped on READYO.
// Follows SEQ_DIVIDER_SIGNED_EN to choose the signed or unsigned reference model.
module tb_seq_divider;

  localparam int WIDTH   = 16;
  localparam int LATENCY = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               readyEdge;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divZero;
  logic             busy;
  logic             readyo;

  int   checks   = 0;
  int   failures = 0;
  int   edgeCnt  = 0;
  exp_t expQ[$];

  seq_divider #(
    .WIDTH(WIDTH)
  ) dut (
    .clk_i      (clock),
    .rst_i      (reset),
    .start_i    (start),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .div_zero_o (divZero),
    .busy_o     (busy),
    .readyo_o   (readyo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.readyEdge = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      e.q  = 16'h8000;
      e.r  = '0;
      e.dz = 1'b0;
    end else begin
      e.q  = WIDTH'($signed(a) / $signed(b));
      e.r  = WIDTH'($signed(a) % $signed(b));
      e.dz = 1'b0;
`else
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
`endif
    end
    return e;
  endfunction

  // Drives one START pulse that the DUT accepts at the next rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                               input logic edz, input bit expectResult);
    exp_t e;
    @(negedge clock);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (expectResult) begin
      e.q         = eq;
      e.r         = er;
      e.dz        = edz;
      e.readyEdge = edgeCnt + LATENCY;
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  task automatic monitorLoop();
    exp_t             e;
    logic [WIDTH-1:0] holdQ  = '0;
    logic [WIDTH-1:0] holdR  = '0;
    logic             holdDz = 1'b0;
    bit               holdValid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        holdValid = 1'b0;
      end else if (readyo) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("quotient", 32'(quotient), 32'(e.q));
          checkOutput("remainder", 32'(remainder), 32'(e.r));
          checkOutput("div_zero", 32'(divZero), 32'(e.dz));
          checkOutput("ready_edge", 32'(edgeCnt), 32'(e.readyEdge));
          checkOutput("busy_at_ready", 32'(busy), 32'd1);
        end
        holdQ     = quotient;
        holdR     = remainder;
        holdDz    = divZero;
        holdValid = 1'b1;
      end else if (holdValid) begin
        checkOutput("hold_quotient", 32'(quotient), 32'(holdQ));
        checkOutput("hold_remainder", 32'(remainder), 32'(holdR));
        checkOutput("hold_div_zero", 32'(divZero), 32'(holdDz));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    exp_t             e;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_div_zero", 32'(divZero), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(readyo), 32'd0);
    #1 reset = 1'b0;

    $display("[TB] basic division with latency check");
    applyStimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("busy_in_calc", 32'(busy), 32'd1);
    waitDrain(LATENCY + 10);

    $display("[TB] START held while busy, then accepted in the idle cycle");
    applyStimulus(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    repeat (WIDTH + 3) @(posedge clock);
    #1;
    start = 1'b0;
    e.q         = 16'd3;
    e.r         = 16'd0;
    e.dz        = 1'b0;
    e.readyEdge = edgeCnt + LATENCY;
    expQ.push_back(e);
    waitDrain(2 * LATENCY + 10);

    $display("[TB] divide by zero");
    applyStimulus(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b1);
    waitDrain(LATENCY + 10);

    $display("[TB] reset during CALC aborts the operation");
    applyStimulus(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_quotient", 32'(quotient), 32'd0);
    checkOutput("abort_remainder", 32'(remainder), 32'd0);
    checkOutput("abort_div_zero", 32'(divZero), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(readyo), 32'd0);
    #1 reset = 1'b0;
    repeat (LATENCY + 5) @(posedge clock);
    applyStimulus(16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);

`ifdef SEQ_DIVIDER_SIGNED_EN
    $display("[TB] signed corner cases");
    applyStimulus(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
    applyStimulus(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
    applyStimulus(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
    applyStimulus(16'h8000, 16'd0, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    waitDrain(LATENCY + 10);
`else
    $display("[TB] unsigned corner cases");
    applyStimulus(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
    applyStimulus(16'd5, 16'hFFFF, 16'd0, 16'd5, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
    applyStimulus(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 1'b1);
    waitDrain(LATENCY + 10);
`endif

    $display("[TB] random vectors against reference model");
    for (int i = 0; i < 150; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = WIDTH'($urandom_range(1, 15));
        2:       b = WIDTH'($urandom);
        default: b = (i % 2 == 0) ? 16'hFFFF : 16'd1;
      endcase
      if (i % 10 == 0) a = 16'h8000;
      e = refModel(a, b);
      applyStimulus(a, b, e.q, e.r, e.dz, 1'b1);
      waitDrain(LATENCY + 10);
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
